// File: rtl/game_defs.sv
// Shared game definitions: state encodings seen by the timer and display stages,
// plus default timing constants and a counter-width helper.
package game_defs;

  typedef enum logic [1:0] {
    ST_START = 2'b00,
    ST_INSTR = 2'b01,
    ST_GAME  = 2'b10,
    ST_SCORE = 2'b11
  } game_state_t;

  localparam int DEF_CLK_FREQ   = 100_000_000;
  localparam int DEF_GAME_TIME  = 60;
  localparam int DEF_SCORE_TIME = 5;
  localparam int DEF_SCORE_W    = 8;

  // Never returns 0 so a degenerate one-cycle hold still yields a legal vector.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/click_edge.sv
// Rising-edge detector for a synchronous button level. The history flop resets
// to 1 so a button held through reset release never produces a click.
module click_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic click
);

  logic btn_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) btn_d <= 1'b1;
    else     btn_d <= btn;
  end

  assign click = btn & ~btn_d;

endmodule

// File: rtl/game_fsm.sv
// Top-level game state controller: START -> INSTR -> GAME -> SCORE -> START,
// round hit counter with saturation, and timed auto-return from the SCORE screen.
module game_fsm
  import game_defs::*;
#(
  parameter int CLK_FREQ   = DEF_CLK_FREQ,
  parameter int SCORE_TIME = DEF_SCORE_TIME,
  parameter int SCORE_W    = DEF_SCORE_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mouse_left,
  input  logic               target_hit,
  input  logic               end_of_time,
  output logic [1:0]         state_out,
  output logic [SCORE_W-1:0] score,
  output logic               game_start
);

  localparam int SCORE_CYCLES = CLK_FREQ * SCORE_TIME;
  localparam int CW           = cnt_width(SCORE_CYCLES);
  localparam logic [CW-1:0] SCORE_LAST = CW'(SCORE_CYCLES - 1);

  // Inputs are single-cycle pulses or levels sampled at every posedge; there is
  // no handshake, so a pulse is acted on in exactly the cycle it is high.
  logic               click;
  game_state_t        state, state_nxt;
  logic [SCORE_W-1:0] score_nxt;
  logic               game_start_nxt;
  logic [CW-1:0]      cnt, cnt_nxt;

  click_edge u_click_edge (
    .clk   (clk),
    .rst   (rst),
    .btn   (mouse_left),
    .click (click)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_START;
      score      <= '0;
      game_start <= 1'b0;
      cnt        <= '0;
    end else begin
      state      <= state_nxt;
      score      <= score_nxt;
      game_start <= game_start_nxt;
      cnt        <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    score_nxt      = score;
    game_start_nxt = 1'b0;
    cnt_nxt        = '0;
    case (state)
      ST_START: if (click) state_nxt = ST_INSTR;
      ST_INSTR: begin
        if (click) begin
          state_nxt      = ST_GAME;
          score_nxt      = '0;
          game_start_nxt = 1'b1;
        end
      end
      ST_GAME: begin
        // A hit coinciding with end_of_time still counts.
        if (target_hit && (score != '1)) score_nxt = score + 1'b1;
        if (end_of_time) state_nxt = ST_SCORE;
      end
      ST_SCORE: begin
        if (click || (cnt == SCORE_LAST)) state_nxt = ST_START;
        else                              cnt_nxt   = cnt + 1'b1;
      end
      default: state_nxt = ST_START;
    endcase
  end

  assign state_out = state;

endmodule

// File: tb/tb_game_fsm.sv
// Directed bench for game_fsm: drivers push expected outputs into a queue and a
// monitor pops one entry per clock and compares it with the DUT outputs.
module tb_game_fsm;

  localparam logic [1:0] S_START = 2'b00;
  localparam logic [1:0] S_INSTR = 2'b01;
  localparam logic [1:0] S_GAME  = 2'b10;
  localparam logic [1:0] S_SCORE = 2'b11;
  localparam int W = 11;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mouse_left = 1'b1;
  logic       target_hit = 1'b0;
  logic       end_of_time = 1'b0;
  logic [1:0] state_out;
  logic [7:0] score;
  logic       game_start;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_v, got_v;
  int checks = 0;
  int errors = 0;

  game_fsm #(.CLK_FREQ(10), .SCORE_TIME(2), .SCORE_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .mouse_left  (mouse_left),
    .target_hit  (target_hit),
    .end_of_time (end_of_time),
    .state_out   (state_out),
    .score       (score),
    .game_start  (game_start)
  );

  always #5 clk = ~clk;

  // Monitor: the outputs are valid every cycle, sampled 1 ns after the edge.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      got_v = {state_out, score, game_start};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL cycle_out t=%0t got state=%b score=%0d gs=%b expected state=%b score=%0d gs=%b",
                 $time, got_v[10:9], got_v[8:1], got_v[0], exp_v[10:9], exp_v[8:1], exp_v[0]);
      end
    end
  end

  task automatic step(input logic ml, input logic th, input logic eot,
                      input logic [1:0] es, input logic [7:0] esc, input logic egs);
    @(negedge clk);
    mouse_left  = ml;
    target_hit  = th;
    end_of_time = eot;
    exp_q.push_back({es, esc, egs});
  endtask

  task automatic check_now(input string name, input logic [1:0] es,
                           input logic [7:0] esc, input logic egs);
    checks++;
    if ({state_out, score, game_start} !== {es, esc, egs}) begin
      errors++;
      $display("FAIL %s got state=%b score=%0d gs=%b expected state=%b score=%0d gs=%b",
               name, state_out, score, game_start, es, esc, egs);
    end
  endtask

  initial begin
    // Reset with the button held through release.
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_now("reset_state", S_START, 8'd0, 1'b0);
    step(1, 0, 0, S_START, 0, 0);
    step(1, 0, 0, S_START, 0, 0);
    step(0, 0, 0, S_START, 0, 0);
    step(1, 0, 0, S_INSTR, 0, 0);
    // Hits and end_of_time outside GAME are ignored; held button is not a click.
    step(1, 1, 0, S_INSTR, 0, 0);
    step(0, 1, 1, S_INSTR, 0, 0);
    step(1, 0, 0, S_GAME, 0, 1);
    step(0, 0, 0, S_GAME, 0, 0);
    for (int i = 1; i <= 7; i++) step(0, 1, 0, S_GAME, 8'(i), 0);
    step(0, 0, 1, S_SCORE, 7, 0);
    // Timeout: START exactly 20 cycles after entering SCORE.
    for (int i = 1; i <= 19; i++) step(0, 0, 0, S_SCORE, 7, 0);
    step(0, 0, 0, S_START, 7, 0);
    step(0, 1, 1, S_START, 7, 0);

    // Second round: score clears on GAME entry, clicks in GAME ignored.
    step(1, 0, 0, S_INSTR, 7, 0);
    step(0, 0, 0, S_INSTR, 7, 0);
    step(1, 0, 0, S_GAME, 0, 1);
    step(1, 0, 0, S_GAME, 0, 0);
    step(0, 0, 0, S_GAME, 0, 0);
    step(1, 0, 0, S_GAME, 0, 0);
    for (int i = 1; i <= 300; i++) step(0, 1, 0, S_GAME, (i > 255) ? 8'd255 : 8'(i), 0);
    step(0, 0, 1, S_SCORE, 255, 0);
    for (int i = 1; i <= 4; i++) step(0, 0, 0, S_SCORE, 255, 0);
    step(1, 0, 0, S_START, 255, 0);
    step(0, 1, 0, S_START, 255, 0);

    // Third round: hit and end_of_time together, then click on the timeout edge.
    step(1, 0, 0, S_INSTR, 255, 0);
    step(0, 1, 0, S_INSTR, 255, 0);
    step(1, 0, 0, S_GAME, 0, 1);
    step(0, 0, 0, S_GAME, 0, 0);
    for (int i = 1; i <= 4; i++) step(0, 1, 0, S_GAME, 8'(i), 0);
    step(0, 1, 1, S_SCORE, 5, 0);
    for (int i = 1; i <= 19; i++) step(0, 0, 0, S_SCORE, 5, 0);
    step(1, 0, 0, S_START, 5, 0);
    step(1, 0, 0, S_START, 5, 0);
    step(0, 0, 0, S_START, 5, 0);

    // Fourth round: asynchronous reset between clock edges.
    step(1, 0, 0, S_INSTR, 5, 0);
    step(0, 0, 0, S_INSTR, 5, 0);
    step(1, 0, 0, S_GAME, 0, 1);
    step(0, 1, 0, S_GAME, 1, 0);
    step(0, 1, 0, S_GAME, 2, 0);
    @(posedge clk);
    #2;
    target_hit = 1'b0;
    rst = 1'b1;
    #1;
    check_now("async_reset", S_START, 8'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    step(0, 1, 1, S_START, 0, 0);
    step(1, 0, 0, S_INSTR, 0, 0);
    step(0, 0, 0, S_INSTR, 0, 0);

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain got %0d pending entries expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
